// File: rtl/i2c_write_arbiter.sv
// i2c_write_arbiter: round-robin sharing of one i2c_master write engine
// between N_REQ clients, with an SCL bit-rate tick divider whose output is
// forwarded to the master only while a granted transfer is running.
// Optional macro I2C_ARB_TIMEOUT_EN adds a per-transfer watchdog that counts
// forwarded ticks and aborts (ack + err + master reset pulse) on expiry.
//
// Handshake: a client raises req[i] and holds it; gnt[i] goes high for the
// whole transfer and ack[i] pulses for exactly one cycle when it finishes
// (err qualifies that pulse). Client addr/data are captured at grant.
module i2c_write_arbiter #(
    parameter int N_REQ         = 4,
    parameter int CLK_DIV       = 250,
    parameter int TIMEOUT_TICKS = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [7*N_REQ-1:0] req_addr,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   ack,
    output logic               err,
    output logic [6:0]         m_addr,
    output logic [7:0]         m_din,
    output logic               m_scl_tick,
    input  logic               m_done,
    output logic               m_rst
);

    localparam int IW = $clog2(N_REQ);
    localparam int DW = $clog2(CLK_DIV);

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_TICKS + 1);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ABORT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

    state_t           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic             tick;
    logic [IW-1:0]    rr_q, rr_d;
    logic [IW-1:0]    win_q, win_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             armed_q, armed_d;
    logic [6:0]       addr_q, addr_d;
    logic [7:0]       din_q, din_d;
    logic             fwd_q, fwd_d;
    logic             found;
    logic [IW-1:0]    pick;
    logic [IW-1:0]    next_ptr;
    logic             finishing;
`ifdef I2C_ARB_TIMEOUT_EN
    logic [WW-1:0]    wdog_q, wdog_d;
`endif

    // Free-running SCL bit-rate divider; tick marks its terminal count.
    always_comb begin
        tick  = (div_q == DW'(CLK_DIV - 1));
        div_d = tick ? '0 : div_q + 1'b1;
    end

    // Round-robin search: first requesting index at or after rr_q, wrapping.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    // Pointer after the current winner, wrapping at N_REQ.
    always_comb begin
        next_ptr = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
    end

    // Next-state and datapath updates for the grant FSM.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        win_d     = win_q;
        armed_d   = armed_q;
        addr_d    = addr_q;
        din_d     = din_q;
        rr_d      = rr_q;
        finishing = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
        wdog_d    = wdog_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    win_d   = pick;
                    addr_d  = req_addr[7*int'(pick) +: 7];
                    din_d   = req_data[8*int'(pick) +: 8];
                    gnt_d   = N_REQ'(1) << pick;
                    armed_d = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
                    wdog_d  = '0;
`endif
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // A done seen before the master has dropped it is stale.
                if (!m_done) armed_d = 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
                if (fwd_q) wdog_d = wdog_q + 1'b1;
`endif
                if (armed_q && m_done) begin
                    state_d = S_DONE;
`ifdef I2C_ARB_TIMEOUT_EN
                end else if (wdog_q == WW'(TIMEOUT_TICKS)) begin
                    state_d = S_ABORT;
`endif
                end
            end
            S_DONE: begin
                finishing = 1'b1;
            end
`ifdef I2C_ARB_TIMEOUT_EN
            S_ABORT: begin
                finishing = 1'b1;
            end
`endif
            default: state_d = S_IDLE;
        endcase
        if (finishing) begin
            gnt_d   = '0;
            rr_d    = next_ptr;
            state_d = S_IDLE;
        end
        // Forward a tick only into cycles that will be spent in RUN.
        fwd_d = tick && (state_d == S_RUN);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            rr_q    <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            armed_q <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            fwd_q   <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            wdog_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            armed_q <= armed_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            fwd_q   <= fwd_d;
`ifdef I2C_ARB_TIMEOUT_EN
            wdog_q  <= wdog_d;
`endif
        end
    end

    // Outputs: ack/err are decoded from the one-cycle completion states.
    always_comb begin
        gnt        = gnt_q;
        m_addr     = addr_q;
        m_din      = din_q;
        m_scl_tick = fwd_q;
        ack        = '0;
        err        = 1'b0;
        m_rst      = !rst;
        if (state_q == S_DONE) ack = gnt_q;
`ifdef I2C_ARB_TIMEOUT_EN
        if (state_q == S_ABORT) begin
            ack   = gnt_q;
            err   = 1'b1;
            m_rst = 1'b1;
        end
`endif
    end

endmodule

// File: doc/i2c_write_arbiter.md
# i2c_write_arbiter

Round-robin controller that shares one `i2c_master` write engine between `N_REQ` requesters. It also generates the SCL bit-rate tick. The tick is forwarded to the master only while a granted transfer is in flight, so the master idles between transfers. It sits between the client blocks (sensor and config writers) and the single `i2c_master` instance on the bus.

## Interface
Parameters:
- `N_REQ`, 4 — number of requesters (2..8).
- `CLK_DIV`, 250 — clk cycles per SCL tick (≥2).
- `TIMEOUT_TICKS`, 128 — forwarded ticks allowed per transfer before abort (only with `I2C_ARB_TIMEOUT_EN`).

Ports:
- `clk`  in  1  — system clock.
- `rst`  in  1  — reset; synchronous, active-low.
- `req`  in  N_REQ  — level request per client; held until that client's `ack` bit pulses.
- `req_addr`  in  7*N_REQ  — 7-bit slave address per client; client i uses bits [7i+6:7i].
- `req_data`  in  8*N_REQ  — write byte per client; client i uses bits [8i+7:8i].
- `gnt`  out  N_REQ  — one-hot, high for the duration of the granted transfer.
- `ack`  out  N_REQ  — one-cycle completion pulse to the granted client.
- `err`  out  1  — high in the same cycle as `ack` when the transfer was aborted.
- `m_addr`  out  7  — address to the master; latched at grant.
- `m_din`  out  8  — data byte to the master; latched at grant.
- `m_scl_tick`  out  1  — gated tick to the master's `scl_tick` input.
- `m_done`  in  1  — master's `done` output.
- `m_rst`  out  1  — active-high reset to the master.

## Operation
- **Tick divider**: free-running counter, 0..CLK_DIV-1. Internal `tick` is high for one cycle when the counter equals CLK_DIV-1. The counter runs in all states and clears on reset.
- **IDLE**
  - If any `req` bit is high, pick a winner by round-robin: search starts at index `rr_ptr` and wraps at N_REQ.
  - Latch the winner's address into `m_addr` and its data into `m_din`.
  - Set `gnt` to the winner's one-hot bit, clear `armed`, and go to RUN.
- **RUN**
  - `m_scl_tick` is a registered copy of `tick`, gated by state == RUN.
  - `armed` is set the first cycle `m_done` is sampled 0. This ignores the stale `done` left high from the previous transfer.
  - When `armed` and `m_done` are both 1, go to DONE.
- **DONE** (one cycle)
  - Pulse `ack[winner]` and hold `err` = 0.
  - Clear `gnt` and set `rr_ptr` = winner+1 mod N_REQ.
  - Go to IDLE.
- **ABORT** (one cycle, timeout build only)
  - Pulse `ack[winner]` with `err` = 1 and pulse `m_rst` = 1.
  - Clear `gnt`, advance `rr_ptr` as in DONE, and go to IDLE.
- **Data stability**: `m_addr` and `m_din` are held stable from grant until the next grant. Client inputs may change once `gnt` is high.
- **Request hold**: a client still holding `req` the cycle after its `ack` is treated as a new request. It is eligible again only after the other active requesters, per `rr_ptr`.
- **Simultaneous requests**: the lowest index at or after `rr_ptr` wins. Requests arriving during RUN wait; none are lost while `req` is held.
- **Dropped request**: a `req` that drops during RUN does not cancel the transfer. The transfer still completes and `ack` still pulses.
- **`m_rst`**: equals (`rst` == 0) OR the ABORT pulse, so the master is reset whenever the arbiter is.

## Timing
- **Reset values**: `gnt`=0, `ack`=0, `err`=0, `m_addr`=0, `m_din`=0, `m_scl_tick`=0, `m_rst`=1. Also state=IDLE, `rr_ptr`=0, `armed`=0, divider=0, watchdog=0.
- **Reset mid-transfer**: everything returns to the reset values on the next edge. No `ack` is issued for the killed transfer.
- **Grant latency**: `req` sampled high in IDLE → `gnt`, `m_addr` and `m_din` valid on the next edge.
- **First forwarded tick**: arrives at most CLK_DIV cycles after grant.
- **Completion latency**: `m_done` rising with `armed` set → DONE on the next edge. `ack` is high for that one cycle.
- **Back-to-back**: the minimum gap between transfers is DONE + IDLE, i.e. 2 cycles from `ack` to the next `gnt`.
- **Tick gating**: `m_scl_tick` is never high outside RUN. It is a single-cycle pulse, exactly one per CLK_DIV cycles.

## Configuration
- `I2C_ARB_TIMEOUT_EN` defined:
  - A watchdog counts forwarded ticks in RUN and clears on grant.
  - When the count reaches TIMEOUT_TICKS without completion, go to ABORT.
- `I2C_ARB_TIMEOUT_EN` undefined:
  - No watchdog and no ABORT state; `err` is tied to 0.
  - `m_rst` = (`rst` == 0) only.
  - RUN waits indefinitely for `m_done`.

## Test plan
- **Single request** (CLK_DIV=4, N_REQ=4): `req`=0001, addr 0x50, data 0xA5 → `gnt`=0001 next cycle, `m_addr`=0x50, `m_din`=0xA5. The master model's decoded bus shows 0x50/W then 0xA5. `ack`=0001 is a one-cycle pulse and `err`=0.
- **Round-robin**: `req`=1111 held throughout → grant order 0,1,2,3,0. Exactly one `gnt` bit is high at a time, and `m_scl_tick` is 0 in every non-RUN cycle.
- **Stale done**: `m_done` is still 1 from the previous transfer at the new grant → no premature `ack`. `ack` comes only after `m_done` goes 0 then returns to 1.
- **Timeout** (TIMEOUT_TICKS=64, macro on): `m_done` stuck at 0 → after 64 forwarded ticks, `ack` and `err`=1 in the same cycle, with a one-cycle `m_rst` pulse. The next request proceeds normally.
- **Reset mid-transfer**: `rst`=0 for one cycle during RUN → all outputs return to reset values with `m_rst`=1 in that cycle. No `ack` is issued, and the next grant starts from index 0.
- **Macro off**: `m_done` stuck at 0 for 1000 ticks → `gnt` stays high and `err` stays 0 throughout.
